// File: rtl/divider_remultiplier_check.sv
`default_nettype none
// ============================================================================
// Module   : divider_remultiplier_check
// Purpose  : Sequential shift-add re-multiplier; rebuilds n_rec = q*d + r from
//            a divider result and reports the exact signed error n - n_rec.
// Revision : 1.0 - initial release
// ============================================================================
module divider_remultiplier_check #(
    parameter int WIDTH = 8
) (
    input  logic                 clk,
    input  logic                 rst,
    input  logic                 in_valid,
    output logic                 in_ready,
    input  logic [WIDTH-1:0]     q,
    input  logic [WIDTH-1:0]     d,
    input  logic [WIDTH-1:0]     r,
    input  logic [2*WIDTH-1:0]   n,
    output logic                 out_valid,
    input  logic                 out_ready,
    output logic [2*WIDTH-1:0]   n_rec,
    output logic [2*WIDTH:0]     err,
    output logic                 busy
);

    localparam int              CW     = $clog2(WIDTH + 1);
    localparam logic [CW-1:0]   C_LAST = CW'(WIDTH);

    typedef enum logic [1:0] {
        S_IDLE = 2'd0,
        S_MUL  = 2'd1,
        S_DONE = 2'd2
    } state_t;

    state_t              r_state;
    state_t              w_state_next;
    logic [WIDTH-1:0]    r_q_sr;
    logic [2*WIDTH:0]    r_mcand;
    logic [2*WIDTH:0]    r_acc;
    logic [2*WIDTH-1:0]  r_n;
    logic [2*WIDTH-1:0]  r_n_rec;
    logic [2*WIDTH:0]    r_err;
    logic [CW-1:0]       r_cnt;

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= S_IDLE;
        end else begin
            r_state <= w_state_next;
        end
    end

    always_comb begin
        w_state_next = r_state;
        in_ready     = 1'b0;
        busy         = 1'b0;
        out_valid    = 1'b0;
        case (r_state)
            S_IDLE: begin
                in_ready = 1'b1;
                if (in_valid) begin
                    w_state_next = S_MUL;
                end
            end
            S_MUL: begin
                busy = 1'b1;
                if (r_cnt == C_LAST) begin
                    w_state_next = S_DONE;
                end
            end
            S_DONE: begin
                out_valid = 1'b1;
                if (out_ready) begin
                    w_state_next = S_IDLE;
                end
            end
            default: w_state_next = S_IDLE;
        endcase
    end

    // Multiplier bits are consumed LSB-first from a shift register while the
    // multiplicand walks left; the extra cycle at cnt==WIDTH registers results.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_q_sr  <= '0;
            r_mcand <= '0;
            r_acc   <= '0;
            r_n     <= '0;
            r_n_rec <= '0;
            r_err   <= '0;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_IDLE: begin
                    if (in_valid) begin
                        r_q_sr  <= q;
                        r_mcand <= {{(WIDTH+1){1'b0}}, d};
                        r_acc   <= {{(WIDTH+1){1'b0}}, r};
                        r_n     <= n;
                        r_cnt   <= '0;
                    end
                end
                S_MUL: begin
                    if (r_cnt == C_LAST) begin
                        r_n_rec <= r_acc[2*WIDTH-1:0];
                        r_err   <= {1'b0, r_n} - r_acc;
                    end else begin
                        if (r_q_sr[0]) begin
                            r_acc <= r_acc + r_mcand;
                        end
                        r_mcand <= r_mcand << 1;
                        r_q_sr  <= r_q_sr >> 1;
                        r_cnt   <= r_cnt + CW'(1);
                    end
                end
                default: begin
                end
            endcase
        end
    end

    assign n_rec = r_n_rec;
    assign err   = r_err;

endmodule
`default_nettype wire

// File: tb/tb_divider_remultiplier_check.sv
`default_nettype none
// ============================================================================
// Module   : tb_divider_remultiplier_check
// Purpose  : Directed self-checking bench for divider_remultiplier_check.
// Revision : 1.0 - initial release
// ============================================================================
module tb_divider_remultiplier_check;

    logic        clk;
    logic        rst;
    logic        in_valid;
    logic        in_ready;
    logic [7:0]  q;
    logic [7:0]  d;
    logic [7:0]  r;
    logic [15:0] n;
    logic        out_valid;
    logic        out_ready;
    logic [15:0] n_rec;
    logic [16:0] err;
    logic        busy;

    int vectors;
    int miscompares;

    divider_remultiplier_check #(.WIDTH(8)) dut (
        .clk       (clk),
        .rst       (rst),
        .in_valid  (in_valid),
        .in_ready  (in_ready),
        .q         (q),
        .d         (d),
        .r         (r),
        .n         (n),
        .out_valid (out_valid),
        .out_ready (out_ready),
        .n_rec     (n_rec),
        .err       (err),
        .busy      (busy)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        vectors++;
        assert (obs === exp) else begin
            miscompares++;
            $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
        end
    endtask

    // One transaction; hold > 0 keeps out_ready low for that many DONE cycles
    // while a changed operand set is offered on the input.
    task automatic run_vec(input string tag, input logic [7:0] vq, input logic [7:0] vd,
                           input logic [7:0] vr, input logic [15:0] vn,
                           input logic [15:0] exp_nrec, input logic [16:0] exp_err,
                           input int hold);
        int cyc;
        logic bad;
        q = vq; d = vd; r = vr; n = vn;
        in_valid  = 1'b1;
        out_ready = (hold == 0);
        check({tag, " in_ready_idle"}, {31'd0, in_ready}, 32'd1);
        step();
        in_valid = 1'b0;
        q = ~vq; d = ~vd; r = ~vr; n = ~vn;
        cyc = 0;
        bad = 1'b0;
        while (out_valid !== 1'b1 && cyc < 20) begin
            if (in_ready !== 1'b0 || busy !== 1'b1) bad = 1'b1;
            step();
            cyc++;
        end
        check({tag, " mul_flags"}, {31'd0, bad}, 32'd0);
        check({tag, " latency"}, cyc, 32'd9);
        check({tag, " n_rec"}, {16'd0, n_rec}, {16'd0, exp_nrec});
        check({tag, " err"}, {15'd0, err}, {15'd0, exp_err});
        bad = 1'b0;
        for (int i = 0; i < hold; i++) begin
            in_valid = 1'b1;
            q = 8'h55; d = 8'hAA; r = 8'h11; n = 16'h1234;
            step();
            if (out_valid !== 1'b1 || in_ready !== 1'b0 || n_rec !== exp_nrec || err !== exp_err)
                bad = 1'b1;
        end
        if (hold > 0) check({tag, " hold_stable"}, {31'd0, bad}, 32'd0);
        in_valid  = 1'b0;
        out_ready = 1'b1;
        step();
        check({tag, " out_valid_drop"}, {31'd0, out_valid}, 32'd0);
        check({tag, " in_ready_back"}, {31'd0, in_ready}, 32'd1);
        out_ready = 1'b0;
    endtask

    initial begin
        logic bad;
        vectors     = 0;
        miscompares = 0;
        rst       = 1'b1;
        in_valid  = 1'b0;
        out_ready = 1'b0;
        q = 8'h00; d = 8'h00; r = 8'h00; n = 16'h0000;
        step();
        step();
        check("reset out_valid", {31'd0, out_valid}, 32'd0);
        check("reset in_ready",  {31'd0, in_ready},  32'd1);
        check("reset busy",      {31'd0, busy},      32'd0);
        check("reset n_rec",     {16'd0, n_rec},     32'd0);
        check("reset err",       {15'd0, err},       32'd0);
        rst = 1'b0;
        step();

        // 15*37+3 = 555+3 = 558
        run_vec("t1_exact", 8'h0F, 8'h25, 8'h03, 16'h022E, 16'h022E, 17'h00000, 0);
        // 255*255+255 = 65280, no wrap
        run_vec("t2_allones", 8'hFF, 8'hFF, 8'hFF, 16'hFF00, 16'hFF00, 17'h00000, 0);
        // 16*37 = 592 = 0x250; 558-592 = -34
        run_vec("t3_negerr", 8'h10, 8'h25, 8'h00, 16'h022E, 16'h0250, 17'h1FFDE, 0);
        run_vec("t4_dzero", 8'h7A, 8'h00, 8'h05, 16'h0005, 16'h0005, 17'h00000, 0);
        // 33*7+3 = 234 = 0xEA; 0xF0-0xEA = 6
        run_vec("t5_backpr", 8'h21, 8'h07, 8'h03, 16'h00F0, 16'h00EA, 17'h00006, 5);

        // Reset in the middle of MUL
        q = 8'hB3; d = 8'h5C; r = 8'h07; n = 16'h0000;
        in_valid = 1'b1;
        step();
        in_valid = 1'b0;
        step(); step(); step();
        check("t6 busy_before_rst", {31'd0, busy}, 32'd1);
        rst = 1'b1;
        #1;
        check("t6 rst out_valid", {31'd0, out_valid}, 32'd0);
        check("t6 rst in_ready",  {31'd0, in_ready},  32'd1);
        check("t6 rst busy",      {31'd0, busy},      32'd0);
        check("t6 rst n_rec",     {16'd0, n_rec},     32'd0);
        check("t6 rst err",       {15'd0, err},       32'd0);
        step();
        rst = 1'b0;
        bad = 1'b0;
        for (int i = 0; i < 12; i++) begin
            step();
            if (out_valid !== 1'b0 || in_ready !== 1'b1) bad = 1'b1;
        end
        check("t6 no_out_pulse", {31'd0, bad}, 32'd0);
        // 13*19+2 = 249 = 0xF9; 0x100-0xF9 = 7
        run_vec("t6_fresh", 8'h0D, 8'h13, 8'h02, 16'h0100, 16'h00F9, 17'h00007, 0);

        $display("== %0d vectors applied, %0d miscompares ==", vectors, miscompares);
        $finish;
    end

endmodule
`default_nettype wire
